// File: rtl/tt_proj_sel_ctrl.sv
// Project-select controller: isolates, resets and enables one project slot at a time.
// Optional macro TT_PROJ_SEL_OUT_REG_EN registers the uo_out/uio_out/uio_oe mux.
module tt_proj_sel_ctrl #(
    parameter int unsigned NUM_PROJ  = 16,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned GUARD_CYC = 4,
    parameter int unsigned RST_CYC   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sel_inc,
    input  logic                     sel_clr,
    input  logic                     ctrl_ena,
    input  logic                     proj_clk_in,
    input  logic                     proj_rst_n_in,
    input  logic [7:0]               ui_in,
    input  logic [7:0]               uio_in,
    input  logic [24*NUM_PROJ-1:0]   ow_all,
    output logic [17:0]              iw,
    output logic [NUM_PROJ-1:0]      ena,
    output logic [7:0]               uo_out,
    output logic [7:0]               uio_out,
    output logic [7:0]               uio_oe,
    output logic                     busy,
    output logic [ADDR_W-1:0]        sel_addr
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned IDX_W = ADDR_W + 5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWITCH = 2'd1,
        S_RESET  = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [ADDR_W-1:0]   r_sel_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                r_inc_d;
    logic                w_inc_edge;
    logic                w_sel_chg;
    logic                w_act_nxt;
    logic                w_act;
    logic                w_run;
    logic [NUM_PROJ-1:0] r_ena;
    logic [15:0]         r_iw_hi;
    logic                r_busy;
    logic [IDX_W-1:0]    w_base;
    logic [23:0]         w_slice;
    logic [23:0]         w_out;

    // Select address update: clear beats increment, increment wraps at the last slot
    always_comb begin
        w_inc_edge = sel_inc & ~r_inc_d;
        w_addr_nxt = r_sel_addr;
        if (sel_clr) begin
            w_addr_nxt = '0;
        end else if (w_inc_edge) begin
            w_addr_nxt = (r_sel_addr == ADDR_W'(NUM_PROJ - 1)) ? '0 : r_sel_addr + ADDR_W'(1);
        end
        w_sel_chg = sel_clr | (w_addr_nxt != r_sel_addr);
    end

    // Next state: ctrl_ena dominates, then a select change restarts the guard window
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!ctrl_ena) begin
            w_state_nxt = S_IDLE;
        end else if (r_state == S_IDLE || w_sel_chg) begin
            w_state_nxt = S_SWITCH;
            w_cnt_nxt   = CNT_W'(GUARD_CYC - 1);
        end else begin
            case (r_state)
                S_SWITCH: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_RESET;
                        w_cnt_nxt   = CNT_W'(RST_CYC - 1);
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                S_RESET: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
        w_act_nxt = (w_state_nxt == S_RESET) || (w_state_nxt == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sel_addr <= '0;
            r_inc_d    <= 1'b0;
            r_ena      <= '0;
            r_iw_hi    <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sel_addr <= w_addr_nxt;
            r_inc_d    <= sel_inc;
            r_ena      <= w_act_nxt ? (NUM_PROJ'(1) << w_addr_nxt) : '0;
            r_iw_hi    <= w_act_nxt ? {uio_in, ui_in} : '0;
            r_busy     <= (w_state_nxt == S_SWITCH) || (w_state_nxt == S_RESET);
        end
    end

    assign w_act  = (r_state == S_RESET) || (r_state == S_RUN);
    assign w_run  = (r_state == S_RUN);
    assign w_base = IDX_W'(r_sel_addr) * IDX_W'(24);
    assign w_slice = ow_all[w_base +: 24];

    // Project clock and reset bits bypass the register so the project sees them unretimed
    assign iw       = {r_iw_hi, w_run & proj_rst_n_in, w_act & proj_clk_in};
    assign ena      = r_ena;
    assign busy     = r_busy;
    assign sel_addr = r_sel_addr;

`ifdef TT_PROJ_SEL_OUT_REG_EN
    logic [23:0] r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_act_nxt ? w_slice : '0;
        end
    end

    assign w_out = r_out;
`else
    assign w_out = w_act ? w_slice : '0;
`endif

    assign {uio_oe, uio_out, uo_out} = w_out;

endmodule

// File: tb/tb_tt_proj_sel_ctrl.sv
// Directed self-checking bench for tt_proj_sel_ctrl (default parameters).
module tb_tt_proj_sel_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sel_inc;
    logic          sel_clr;
    logic          ctrl_ena;
    logic          proj_clk_in;
    logic          proj_rst_n_in;
    logic [7:0]    ui_in;
    logic [7:0]    uio_in;
    logic [383:0]  ow_all;
    logic [17:0]   iw;
    logic [15:0]   ena;
    logic [7:0]    uo_out;
    logic [7:0]    uio_out;
    logic [7:0]    uio_oe;
    logic          busy;
    logic [7:0]    sel_addr;

    int n_tests = 0;
    int n_fail  = 0;

    tt_proj_sel_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sel_inc       (sel_inc),
        .sel_clr       (sel_clr),
        .ctrl_ena      (ctrl_ena),
        .proj_clk_in   (proj_clk_in),
        .proj_rst_n_in (proj_rst_n_in),
        .ui_in         (ui_in),
        .uio_in        (uio_in),
        .ow_all        (ow_all),
        .iw            (iw),
        .ena           (ena),
        .uo_out        (uo_out),
        .uio_out       (uio_out),
        .uio_oe        (uio_oe),
        .busy          (busy),
        .sel_addr      (sel_addr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_inc();
        sel_inc = 1'b1;
        tick();
        sel_inc = 1'b0;
        tick();
    endtask

    task automatic wait_run();
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b0) break;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_run: busy=%b required 0 within 40 cycles", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if (ena !== 16'h0 || iw !== 18'h0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ena=%h iw=%h busy=%b required 0/0/0", ena, iw, busy);
        end
        n_tests++;
        if (sel_addr !== 8'h0 || {uio_oe, uio_out, uo_out} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_out: sel_addr=%h out=%h required 0/0", sel_addr, {uio_oe, uio_out, uo_out});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_startup();
        ctrl_ena = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (ena !== 16'h0 || busy !== 1'b1 || iw !== 18'h0) begin
                n_fail++;
                $display("FAIL switch_%0d: ena=%h busy=%b iw=%h required 0/1/0", i, ena, busy, iw);
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            n_tests++;
            if (ena !== 16'h0001 || busy !== 1'b1 || iw !== {8'hC3, 8'h5A, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_seq_%0d: ena=%h busy=%b iw=%h required 0001/1/%h",
                         i, ena, busy, iw, {8'hC3, 8'h5A, 1'b0, 1'b1});
            end
        end
        tick();
        n_tests++;
        if (ena !== 16'h0001 || busy !== 1'b0 || iw !== {8'hC3, 8'h5A, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL run_entry: ena=%h busy=%b iw=%h required 0001/0/%h",
                     ena, busy, iw, {8'hC3, 8'h5A, 1'b1, 1'b1});
        end
        proj_rst_n_in = 1'b0;
        #1;
        n_tests++;
        if (iw[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL run_rst_follow: iw[1]=%b required 0", iw[1]);
        end
        proj_rst_n_in = 1'b1;
    endtask

    task automatic test_sel_inc();
        pulse_inc();
        n_tests++;
        if (sel_addr !== 8'd1 || ena !== 16'h0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL inc_first: sel_addr=%0d ena=%h busy=%b required 1/0/1", sel_addr, ena, busy);
        end
        pulse_inc();
        pulse_inc();
        for (int i = 0; i < 10; i++) tick();
        n_tests++;
        if (sel_addr !== 8'd3 || busy !== 1'b1 || ena !== 16'h0008) begin
            n_fail++;
            $display("FAIL inc_reset_end: sel_addr=%0d busy=%b ena=%h required 3/1/0008", sel_addr, busy, ena);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || ena !== 16'h0008) begin
            n_fail++;
            $display("FAIL inc_run: busy=%b ena=%h required 0/0008", busy, ena);
        end
        n_tests++;
        if (uo_out !== 8'h43 || uio_out !== 8'h83 || uio_oe !== 8'hC3) begin
            n_fail++;
            $display("FAIL mux_slot3: out=%h required c38343", {uio_oe, uio_out, uo_out});
        end
    endtask

    task automatic test_wrap_and_clr();
        for (int i = 0; i < 12; i++) pulse_inc();
        n_tests++;
        if (sel_addr !== 8'd15) begin
            n_fail++;
            $display("FAIL count_to_15: sel_addr=%0d required 15", sel_addr);
        end
        pulse_inc();
        n_tests++;
        if (sel_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap: sel_addr=%0d required 0", sel_addr);
        end
        for (int i = 0; i < 15; i++) pulse_inc();
        n_tests++;
        if (sel_addr !== 8'd15) begin
            n_fail++;
            $display("FAIL recount_15: sel_addr=%0d required 15", sel_addr);
        end
        wait_run();
        sel_inc = 1'b1;
        sel_clr = 1'b1;
        tick();
        n_tests++;
        if (sel_addr !== 8'd0 || busy !== 1'b1 || ena !== 16'h0) begin
            n_fail++;
            $display("FAIL clr_priority: sel_addr=%0d busy=%b ena=%h required 0/1/0", sel_addr, busy, ena);
        end
        sel_inc = 1'b0;
        sel_clr = 1'b0;
        wait_run();
        n_tests++;
        if (ena !== 16'h0001 || sel_addr !== 8'd0) begin
            n_fail++;
            $display("FAIL clr_run: ena=%h sel_addr=%0d required 0001/0", ena, sel_addr);
        end
    endtask

    task automatic test_ow_mux();
        ow_all[23:0] = 24'h000000;
        tick();
        ow_all[23:0] = 24'hA5C33C;
        #1;
`ifdef TT_PROJ_SEL_OUT_REG_EN
        n_tests++;
        if ({uio_oe, uio_out, uo_out} !== 24'h000000) begin
            n_fail++;
            $display("FAIL ow_reg_hold: out=%h required 000000", {uio_oe, uio_out, uo_out});
        end
        tick();
`endif
        n_tests++;
        if (uio_oe !== 8'hA5 || uio_out !== 8'hC3 || uo_out !== 8'h3C) begin
            n_fail++;
            $display("FAIL ow_update: out=%h required a5c33c", {uio_oe, uio_out, uo_out});
        end
    endtask

    task automatic test_ctrl_ena_mid_reset();
        pulse_inc();
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (busy !== 1'b1 || ena !== 16'h0002) begin
            n_fail++;
            $display("FAIL mid_reset_entry: busy=%b ena=%h required 1/0002", busy, ena);
        end
        ctrl_ena = 1'b0;
        tick();
        n_tests++;
        if (ena !== 16'h0 || iw !== 18'h0 || busy !== 1'b0 || {uio_oe, uio_out, uo_out} !== 24'h0) begin
            n_fail++;
            $display("FAIL ctrl_ena_idle: ena=%h iw=%h busy=%b out=%h required all 0",
                     ena, iw, busy, {uio_oe, uio_out, uo_out});
        end
    endtask

    task automatic test_async_reset();
        ctrl_ena = 1'b1;
        wait_run();
        rst_n = 1'b0;
        #2;
        n_tests++;
        if (ena !== 16'h0 || iw !== 18'h0 || busy !== 1'b0 || sel_addr !== 8'h0 ||
            {uio_oe, uio_out, uo_out} !== 24'h0) begin
            n_fail++;
            $display("FAIL async_rst: ena=%h iw=%h busy=%b sel=%h out=%h required all 0",
                     ena, iw, busy, sel_addr, {uio_oe, uio_out, uo_out});
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        n_tests++;
        if (busy !== 1'b1 || ena !== 16'h0001) begin
            n_fail++;
            $display("FAIL post_rst_seq: busy=%b ena=%h required 1/0001", busy, ena);
        end
        tick();
        n_tests++;
        if (busy !== 1'b0 || ena !== 16'h0001) begin
            n_fail++;
            $display("FAIL post_rst_run: busy=%b ena=%h required 0/0001", busy, ena);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        sel_inc       = 1'b0;
        sel_clr       = 1'b0;
        ctrl_ena      = 1'b0;
        proj_clk_in   = 1'b1;
        proj_rst_n_in = 1'b1;
        ui_in         = 8'h5A;
        uio_in        = 8'hC3;
        for (int k = 0; k < 16; k++) begin
            ow_all[24*k +: 24] = {8'(8'hC0 + k), 8'(8'h80 + k), 8'(8'h40 + k)};
        end
        test_reset();
        test_startup();
        test_sel_inc();
        test_wrap_and_clr();
        test_ow_mux();
        test_ctrl_ena_mid_reset();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
